lsu_split: RTL and testbench

- Parametrised sequential load/store unit; successor to the combinational memory extend stage.
- Takes one load/store per handshake from the execute stage and generates aligned bus transactions with write strobes.
- Splits misaligned accesses into two aligned beats, then merges and sign/zero-extends the read data.
- Supports XLEN 32 or 64 (adds LD/LWU/SD on 64); sits between the core pipeline and the data memory bus.

---
 rtl/lsu_split.sv | 190 +++++++++++++++++++
 tb/tb_lsu_split.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - sequential load/store unit that splits misaligned accesses into two aligned beats
module lsu_split #(
  parameter int XLEN        = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_wen,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t state, state_nxt;

  logic [OW-1:0]     off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              wr_q;
  logic              split_q;
  logic              err_q;
  logic [XLEN-1:0]   base_q;
  logic [2*XLEN-1:0] wide_q;
  logic [2*NB-1:0]   mask_q;
  logic [2*XLEN-1:0] buf_q;

  logic              accept;
  logic [OW-1:0]     req_off;
  logic [3:0]        req_nbytes;
  logic [4:0]        req_end;
  logic              req_split;
  logic              req_misal;
  logic              req_err;
  logic [2*NB-1:0]   req_mask;
  logic [2*XLEN-1:0] req_wide;
  logic [XLEN-1:0]   load_ext;

  assign accept = req_valid & req_ready;

  // Decode the incoming request: byte offset, split detection, error cases, store lanes
  always_comb begin
    req_off    = req_addr[OW-1:0];
    req_nbytes = 4'd1 << req_funct3[1:0];
    req_end    = 5'(req_off) + 5'(req_nbytes);
    req_split  = (req_end > 5'(NB));
    // Without split support only naturally aligned accesses are served
    req_misal  = |(4'(req_off) & (req_nbytes - 4'd1));
    req_err    = ((req_funct3[1:0] == 2'd3) && (XLEN == 32)) ||
                 (req_read == req_write) ||
                 (!MISALIGN_EN && req_misal);
    req_mask   = '0;
    for (int i = 0; i < 2*NB; i++) begin
      req_mask[i] = (4'(i) < req_nbytes);
    end
    req_mask   = req_mask << req_off;
    req_wide   = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request attributes latched on accept, read beats merged into the two-beat buffer
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      base_q  <= '0;
      wide_q  <= '0;
      mask_q  <= '0;
      buf_q   <= '0;
    end else begin
      if (accept) begin
        off_q   <= req_off;
        size_q  <= req_funct3[1:0];
        uns_q   <= req_funct3[2];
        wr_q    <= req_write;
        split_q <= req_split;
        err_q   <= req_err;
        base_q  <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
        wide_q  <= req_wide;
        mask_q  <= req_mask;
        buf_q   <= '0;
      end
      if (state == RSP0 && bus_rvalid) begin
        buf_q[XLEN-1:0] <= bus_rdata;
      end
      if (state == RSP1 && bus_rvalid) begin
        buf_q[2*XLEN-1:XLEN] <= bus_rdata;
      end
    end
  end

  // Next-state sequencing through the one or two bus beats
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = req_err ? DONE : REQ0;
      REQ0: if (bus_ready) state_nxt = !wr_q ? RSP0 : (split_q ? REQ1 : DONE);
      RSP0: if (bus_rvalid) state_nxt = split_q ? REQ1 : DONE;
      REQ1: if (bus_ready) state_nxt = wr_q ? DONE : RSP1;
      RSP1: if (bus_rvalid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift the merged beats down to the access offset, then sign/zero extend by size
  always_comb begin
    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   keep;
    logic              sign;
    shifted = buf_q >> {off_q, 3'b000};
    raw     = shifted[XLEN-1:0];
    keep    = '1;
    sign    = 1'b0;
    case (size_q)
      2'd0: begin keep = XLEN'(8'hFF);   sign = raw[7];  end
      2'd1: begin keep = XLEN'(16'hFFFF); sign = raw[15]; end
      2'd2: if (XLEN > 32) begin keep = XLEN'(32'hFFFF_FFFF); sign = raw[31]; end
      default: ;
    endcase
    load_ext = (raw & keep) | ((sign && !uns_q) ? ~keep : '0);
  end

  // Output decode: bus beats in REQx, completion pulse in DONE
  always_comb begin
    req_ready = (state == IDLE);
    bus_valid = 1'b0;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_wstrb = '0;
    bus_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (state)
      REQ0: begin
        bus_valid = 1'b1;
        bus_wen   = wr_q;
        bus_addr  = base_q;
        bus_wstrb = wr_q ? mask_q[NB-1:0] : '0;
        bus_wdata = wr_q ? wide_q[XLEN-1:0] : '0;
      end
      REQ1: begin
        bus_valid = 1'b1;
        bus_wen   = wr_q;
        bus_addr  = base_q + XLEN'(NB);
        bus_wstrb = wr_q ? mask_q[2*NB-1:NB] : '0;
        bus_wdata = wr_q ? wide_q[2*XLEN-1:XLEN] : '0;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !wr_q) rsp_rdata = load_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_split.sv
// tb/tb_lsu_split.sv - scoreboard bench for lsu_split on XLEN=32, XLEN=32 without split, and XLEN=64
module tb_lsu_split;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } beat_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [2:0]  req_v;
  logic [2:0]  req_funct3;
  logic        req_read, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        bus_ready, bus_rvalid;
  logic [63:0] bus_rdata;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_bus_valid, a_bus_wen;
  logic [31:0] a_rsp_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_wstrb;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_bus_valid, b_bus_wen;
  logic [31:0] b_rsp_rdata, b_bus_addr, b_bus_wdata;
  logic [3:0]  b_bus_wstrb;
  logic        c_req_ready, c_rsp_valid, c_rsp_err, c_bus_valid, c_bus_wen;
  logic [63:0] c_rsp_rdata, c_bus_addr, c_bus_wdata;
  logic [7:0]  c_bus_wstrb;

  int          sel;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_bus_valid, o_bus_wen;
  logic [63:0] o_rsp_rdata, o_bus_addr, o_bus_wdata;
  logic [7:0]  o_bus_wstrb;

  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    stall;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  lsu_split #(.XLEN(32), .MISALIGN_EN(1'b1)) u_a (
    .clk(clk), .rst_b(rst_b), .req_valid(req_v[0]), .req_ready(a_req_ready),
    .req_funct3(req_funct3), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
    .bus_valid(a_bus_valid), .bus_ready(bus_ready), .bus_wen(a_bus_wen),
    .bus_addr(a_bus_addr), .bus_wstrb(a_bus_wstrb), .bus_wdata(a_bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata[31:0])
  );

  lsu_split #(.XLEN(32), .MISALIGN_EN(1'b0)) u_b (
    .clk(clk), .rst_b(rst_b), .req_valid(req_v[1]), .req_ready(b_req_ready),
    .req_funct3(req_funct3), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .bus_valid(b_bus_valid), .bus_ready(bus_ready), .bus_wen(b_bus_wen),
    .bus_addr(b_bus_addr), .bus_wstrb(b_bus_wstrb), .bus_wdata(b_bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata[31:0])
  );

  lsu_split #(.XLEN(64), .MISALIGN_EN(1'b1)) u_c (
    .clk(clk), .rst_b(rst_b), .req_valid(req_v[2]), .req_ready(c_req_ready),
    .req_funct3(req_funct3), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(c_rsp_valid), .rsp_err(c_rsp_err), .rsp_rdata(c_rsp_rdata),
    .bus_valid(c_bus_valid), .bus_ready(bus_ready), .bus_wen(c_bus_wen),
    .bus_addr(c_bus_addr), .bus_wstrb(c_bus_wstrb), .bus_wdata(c_bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // Observe whichever instance is currently under test
  always_comb begin
    case (sel)
      1: begin
        o_req_ready = b_req_ready; o_rsp_valid = b_rsp_valid; o_rsp_err = b_rsp_err;
        o_rsp_rdata = 64'(b_rsp_rdata); o_bus_valid = b_bus_valid; o_bus_wen = b_bus_wen;
        o_bus_addr = 64'(b_bus_addr); o_bus_wstrb = 8'(b_bus_wstrb); o_bus_wdata = 64'(b_bus_wdata);
      end
      2: begin
        o_req_ready = c_req_ready; o_rsp_valid = c_rsp_valid; o_rsp_err = c_rsp_err;
        o_rsp_rdata = c_rsp_rdata; o_bus_valid = c_bus_valid; o_bus_wen = c_bus_wen;
        o_bus_addr = c_bus_addr; o_bus_wstrb = c_bus_wstrb; o_bus_wdata = c_bus_wdata;
      end
      default: begin
        o_req_ready = a_req_ready; o_rsp_valid = a_rsp_valid; o_rsp_err = a_rsp_err;
        o_rsp_rdata = 64'(a_rsp_rdata); o_bus_valid = a_bus_valid; o_bus_wen = a_bus_wen;
        o_bus_addr = 64'(a_bus_addr); o_bus_wstrb = 8'(a_bus_wstrb); o_bus_wdata = 64'(a_bus_wdata);
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [63:0] addr, input logic wen, input logic [7:0] wstrb,
                           input logic [63:0] wdata, input logic [63:0] rdata);
    beat_t b;
    b.addr = addr; b.wen = wen; b.wstrb = wstrb; b.wdata = wdata; b.rdata = rdata;
    beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [63:0] rdata, input logic err, input int lat);
    rsp_t r;
    r.rdata = rdata; r.err = err; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  // Issue one request, act as the bus slave from the beat queue, and score the response
  task automatic run_op(input int s, input logic [2:0] f3, input logic rd, input logic wr,
                        input logic [63:0] addr, input logic [63:0] wdata);
    beat_t       b;
    rsp_t        r;
    logic        pend;
    logic [63:0] pend_data;
    logic        done;
    @(negedge clk);
    sel = s; req_funct3 = f3; req_read = rd; req_write = wr;
    req_addr = addr; req_wdata = wdata; req_v = '0; req_v[s] = 1'b1;
    #1;
    check_eq("req_ready_idle", 64'(o_req_ready), 64'd1);
    pend = 1'b0; pend_data = '0; done = 1'b0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      req_v = '0; bus_rvalid = 1'b0; bus_rdata = '0; bus_ready = 1'b1;
      if (pend) begin
        bus_rvalid = 1'b1; bus_rdata = pend_data; pend = 1'b0;
      end
      #1;
      if (o_bus_valid) begin
        if (beat_q.size() == 0) begin
          check_eq("bus_unexpected", 64'(o_bus_valid), 64'd0);
        end else begin
          b = beat_q[0];
          check_eq("bus_addr", o_bus_addr, b.addr);
          check_eq("bus_wen", 64'(o_bus_wen), 64'(b.wen));
          check_eq("bus_wstrb", 64'(o_bus_wstrb), 64'(b.wstrb));
          if (b.wen) check_eq("bus_wdata", o_bus_wdata, b.wdata);
          if (stall > 0) begin
            bus_ready = 1'b0;
            stall--;
          end else begin
            void'(beat_q.pop_front());
            if (!b.wen) begin
              pend = 1'b1; pend_data = b.rdata;
            end
          end
        end
      end
      if (o_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'(o_rsp_valid), 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check_eq("rsp_rdata", o_rsp_rdata, r.rdata);
          check_eq("rsp_err", 64'(o_rsp_err), 64'(r.err));
          check_eq("rsp_latency", 64'(n), 64'(r.lat));
        end
        done = 1'b1;
      end
    end
    check_eq("rsp_seen", 64'(done), 64'd1);
    @(negedge clk);
    bus_rvalid = 1'b0; bus_ready = 1'b1;
    #1;
    check_eq("rsp_one_pulse", 64'(o_rsp_valid), 64'd0);
    check_eq("ready_after", 64'(o_req_ready), 64'd1);
    check_eq("beats_left", 64'(beat_q.size()), 64'd0);
    beat_q.delete();
    rsp_q.delete();
    stall = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_rsp;
    rst_b = 1'b0; req_v = '0; req_funct3 = '0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
    sel = 0; stall = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("rst_req_ready", 64'(o_req_ready), 64'd1);
      check_eq("rst_bus_valid", 64'(o_bus_valid), 64'd0);
      check_eq("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      check_eq("rst_bus_addr", o_bus_addr, 64'd0);
      check_eq("rst_bus_wstrb", 64'(o_bus_wstrb), 64'd0);
      check_eq("rst_rsp_rdata", o_rsp_rdata, 64'd0);
    end
    @(negedge clk);
    rst_b = 1'b1;

    // XLEN=32, split enabled
    push_beat(64'h1000, 0, 8'h0, 64'h0, 64'h8000_0000); push_rsp(64'hFFFF_FF80, 0, 3);
    run_op(0, 3'b000, 1, 0, 64'h1003, 64'h0);
    push_beat(64'h1000, 0, 8'h0, 64'h0, 64'h8000_0000); push_rsp(64'h0000_0080, 0, 3);
    run_op(0, 3'b100, 1, 0, 64'h1003, 64'h0);
    push_beat(64'h2000, 1, 8'hC, 64'hBEEF_0000, 64'h0); push_rsp(64'h0, 0, 2);
    run_op(0, 3'b001, 0, 1, 64'h2002, 64'h0000_BEEF);
    push_beat(64'h3000, 0, 8'h0, 64'h0, 64'h4433_2211);
    push_beat(64'h3004, 0, 8'h0, 64'h0, 64'h8877_6655); push_rsp(64'h7766_5544, 0, 5);
    run_op(0, 3'b010, 1, 0, 64'h3003, 64'h0);
    push_beat(64'h1000, 1, 8'hC, 64'hCCDD_0000, 64'h0);
    push_beat(64'h1004, 1, 8'h3, 64'h0000_AABB, 64'h0); push_rsp(64'h0, 0, 3);
    run_op(0, 3'b010, 0, 1, 64'h1002, 64'hAABB_CCDD);
    push_beat(64'h1000, 0, 8'h0, 64'h0, 64'h00AB_CD00); push_rsp(64'hFFFF_ABCD, 0, 3);
    run_op(0, 3'b001, 1, 0, 64'h1001, 64'h0);
    push_beat(64'hFFFF_FFFC, 0, 8'h0, 64'h0, 64'h1200_0000);
    push_beat(64'h0000_0000, 0, 8'h0, 64'h0, 64'h0000_0034); push_rsp(64'h0000_3412, 0, 5);
    run_op(0, 3'b101, 1, 0, 64'hFFFF_FFFF, 64'h0);
    stall = 2;
    push_beat(64'h1000, 1, 8'h2, 64'h3456_5A00, 64'h0); push_rsp(64'h0, 0, 4);
    run_op(0, 3'b000, 0, 1, 64'h1001, 64'h1234_565A);
    push_rsp(64'h0, 1, 1);
    run_op(0, 3'b011, 1, 0, 64'h1000, 64'h0);
    push_rsp(64'h0, 1, 1);
    run_op(0, 3'b010, 1, 1, 64'h1000, 64'h0);

    // XLEN=32, split disabled
    push_rsp(64'h0, 1, 1);
    run_op(1, 3'b001, 1, 0, 64'h5001, 64'h0);
    push_rsp(64'h0, 1, 1);
    run_op(1, 3'b010, 1, 0, 64'h5003, 64'h0);
    push_beat(64'h5004, 0, 8'h0, 64'h0, 64'hDEAD_BEEF); push_rsp(64'hDEAD_BEEF, 0, 3);
    run_op(1, 3'b010, 1, 0, 64'h5004, 64'h0);

    // XLEN=64
    push_beat(64'h4000, 1, 8'hC0, 64'h0708_0000_0000_0000, 64'h0);
    push_beat(64'h4008, 1, 8'h3F, 64'h0000_0102_0304_0506, 64'h0); push_rsp(64'h0, 0, 3);
    run_op(2, 3'b011, 0, 1, 64'h4006, 64'h0102_0304_0506_0708);
    push_beat(64'h4000, 0, 8'h0, 64'h0, 64'h1234_5678_FFFF_FFFF); push_rsp(64'h0000_0000_FFFF_FFFF, 0, 3);
    run_op(2, 3'b110, 1, 0, 64'h4000, 64'h0);
    push_beat(64'h4000, 0, 8'h0, 64'h0, 64'h1234_5678_FFFF_FFFF); push_rsp(64'hFFFF_FFFF_FFFF_FFFF, 0, 3);
    run_op(2, 3'b010, 1, 0, 64'h4000, 64'h0);
    push_beat(64'h4000, 0, 8'h0, 64'h0, 64'h8877_6655_4433_2211);
    push_beat(64'h4008, 0, 8'h0, 64'h0, 64'hFFEE_DDCC_CCBB_AA99); push_rsp(64'hCCBB_AA99_8877_6655, 0, 5);
    run_op(2, 3'b011, 1, 0, 64'h4004, 64'h0);

    // Backpressure holds the beat, then reset in RSP0 aborts without a response
    @(negedge clk);
    sel = 0; req_funct3 = 3'b010; req_read = 1'b1; req_write = 1'b0;
    req_addr = 64'h6000; req_wdata = 64'h0; req_v = 3'b001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_v = '0; bus_ready = 1'b0;
      #1;
      check_eq("bp_bus_valid", 64'(o_bus_valid), 64'd1);
      check_eq("bp_bus_addr", o_bus_addr, 64'h6000);
      check_eq("bp_bus_wstrb", 64'(o_bus_wstrb), 64'd0);
      check_eq("bp_req_ready", 64'(o_req_ready), 64'd0);
    end
    @(negedge clk);
    bus_ready = 1'b1;
    #1;
    check_eq("bp_release_valid", 64'(o_bus_valid), 64'd1);
    @(negedge clk);
    #1;
    check_eq("rsp0_bus_valid", 64'(o_bus_valid), 64'd0);
    check_eq("rsp0_req_ready", 64'(o_req_ready), 64'd0);
    rst_b = 1'b0;
    #1;
    check_eq("abort_bus_valid", 64'(o_bus_valid), 64'd0);
    check_eq("abort_req_ready", 64'(o_req_ready), 64'd1);
    check_eq("abort_rsp_valid", 64'(o_rsp_valid), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 64'h1111_2222;
    seen_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      if (o_rsp_valid || o_bus_valid) seen_rsp = 1'b1;
    end
    check_eq("abort_no_activity", 64'(seen_rsp), 64'd0);
    check_eq("abort_idle_ready", 64'(o_req_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
